// File: rtl/usb_rx_bit_decoder.sv
// rtl/usb_rx_bit_decoder.sv - USB full-speed receive bit decoder (NRZI, SYNC, de-stuff, bytes, EOP)
//
// Purpose: decodes the synchronized D+ line of a full-speed USB receiver.
//   NRZI-decodes each bit-centre sample, hunts for SYNC and removes stuffed bits.
//   Assembles LSB-first bytes, flags EOP and feeds the serial CRC-16 checker
//   that sits directly downstream.
//
// Ports:
//   clk          system clock
//   nRst         asynchronous active-low reset
//   d_line       synchronized D+ level (idle J = 1)
//   se0          synchronized single-ended-zero indication
//   bit_strobe   one-cycle pulse at each bit-centre sample point
//   crc_din      de-stuffed data bit for the CRC checker (holds when not shifting)
//   crc_shift    pulse: crc_din carries a new payload bit
//   crc_clear    pulse: reset the CRC checker at start of packet
//   rx_byte      last completed byte, first received bit in bit 0
//   byte_valid   pulse: rx_byte updated
//   rcving       high from SYNC match until the EOP has been handled
//   stuff_error  sticky: seven consecutive ones seen, cleared back in IDLE
//   align_error  pulse: EOP arrived with a partial byte
//   eop_seen     pulse on EOP detection
module usb_rx_bit_decoder #(
  parameter int         STUFF_RUN    = 6,
  parameter logic [7:0] SYNC_PATTERN = 8'h80
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       d_line,
  input  logic       se0,
  input  logic       bit_strobe,
  output logic       crc_din,
  output logic       crc_shift,
  output logic       crc_clear,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       rcving,
  output logic       stuff_error,
  output logic       align_error,
  output logic       eop_seen
);

  localparam int                ONES_W      = $clog2(STUFF_RUN + 1);
  localparam logic [ONES_W-1:0] STUFF_LIMIT = ONES_W'(STUFF_RUN);
  localparam logic [ONES_W-1:0] ONES_ONE    = ONES_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP_WAIT,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic              prev_line_q, prev_line_d;
  logic [2:0]        sync_cnt_q, sync_cnt_d;
  logic [ONES_W-1:0] ones_cnt_q, ones_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shreg_q, shreg_d;

  logic       crc_din_d, crc_shift_d, crc_clear_d;
  logic [7:0] rx_byte_d;
  logic       byte_valid_d, rcving_d, stuff_error_d, align_error_d, eop_seen_d;

  // se0 wins over the data bit: an se0 strobe never decodes a bit.
  logic bit_valid, eop_strobe, dbit;
  assign bit_valid  = bit_strobe & ~se0;
  assign eop_strobe = bit_strobe & se0;
  assign dbit       = (d_line == prev_line_q);

  always_comb begin
    state_d       = state_q;
    prev_line_d   = prev_line_q;
    sync_cnt_d    = sync_cnt_q;
    ones_cnt_d    = ones_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    crc_din_d     = crc_din;
    crc_shift_d   = 1'b0;
    crc_clear_d   = 1'b0;
    rx_byte_d     = rx_byte;
    byte_valid_d  = 1'b0;
    rcving_d      = rcving;
    stuff_error_d = stuff_error;
    align_error_d = 1'b0;
    eop_seen_d    = 1'b0;

    if (bit_valid) begin
      prev_line_d = d_line;
    end

    case (state_q)
      S_IDLE: begin
        if (bit_valid && !dbit) begin
          state_d    = S_SYNC;
          sync_cnt_d = 3'd1;
        end
      end

      S_SYNC: begin
        if (eop_strobe) begin
          state_d = S_IDLE;
        end else if (bit_valid) begin
          if (dbit != SYNC_PATTERN[sync_cnt_q]) begin
            state_d = S_IDLE;
          end else if (sync_cnt_q == 3'd7) begin
            // The closing SYNC 1 already counts toward the stuffing run.
            state_d     = S_DATA;
            crc_clear_d = 1'b1;
            rcving_d    = 1'b1;
            ones_cnt_d  = ONES_ONE;
            bit_cnt_d   = 3'd0;
          end else begin
            sync_cnt_d = sync_cnt_q + 3'd1;
          end
        end
      end

      S_DATA: begin
        if (eop_strobe) begin
          state_d       = S_EOP_WAIT;
          eop_seen_d    = 1'b1;
          align_error_d = (bit_cnt_q != 3'd0);
        end else if (bit_valid) begin
          if (ones_cnt_q == STUFF_LIMIT) begin
            if (!dbit) begin
              ones_cnt_d = '0;
            end else begin
              stuff_error_d = 1'b1;
              state_d       = S_ERR;
            end
          end else begin
            crc_din_d   = dbit;
            crc_shift_d = 1'b1;
            // New bits enter at the MSB so the first one ends up in bit 0.
            shreg_d     = {dbit, shreg_q[7:1]};
            ones_cnt_d  = dbit ? (ones_cnt_q + ONES_ONE) : '0;
            bit_cnt_d   = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_byte_d    = {dbit, shreg_q[7:1]};
              byte_valid_d = 1'b1;
            end
          end
        end
      end

      S_EOP_WAIT: begin
        if (bit_valid && d_line) begin
          state_d       = S_IDLE;
          rcving_d      = 1'b0;
          stuff_error_d = 1'b0;
          prev_line_d   = 1'b1;
        end
      end

      S_ERR: begin
        if (eop_strobe) begin
          state_d    = S_EOP_WAIT;
          eop_seen_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= S_IDLE;
      prev_line_q <= 1'b1;
      sync_cnt_q  <= 3'd0;
      ones_cnt_q  <= '0;
      bit_cnt_q   <= 3'd0;
      shreg_q     <= 8'h00;
      crc_din     <= 1'b0;
      crc_shift   <= 1'b0;
      crc_clear   <= 1'b0;
      rx_byte     <= 8'h00;
      byte_valid  <= 1'b0;
      rcving      <= 1'b0;
      stuff_error <= 1'b0;
      align_error <= 1'b0;
      eop_seen    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_line_q <= prev_line_d;
      sync_cnt_q  <= sync_cnt_d;
      ones_cnt_q  <= ones_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      crc_din     <= crc_din_d;
      crc_shift   <= crc_shift_d;
      crc_clear   <= crc_clear_d;
      rx_byte     <= rx_byte_d;
      byte_valid  <= byte_valid_d;
      rcving      <= rcving_d;
      stuff_error <= stuff_error_d;
      align_error <= align_error_d;
      eop_seen    <= eop_seen_d;
    end
  end

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// tb/tb_usb_rx_bit_decoder.sv - self-checking bench for usb_rx_bit_decoder
`timescale 1ns/1ps
module tb_usb_rx_bit_decoder;

  logic       clk = 1'b0;
  logic       nRst, d_line, se0, bit_strobe;
  logic       crc_din, crc_shift, crc_clear, byte_valid, rcving;
  logic       stuff_error, align_error, eop_seen;
  logic [7:0] rx_byte;

  always #5 clk = ~clk;

  usb_rx_bit_decoder dut (
    .clk(clk), .nRst(nRst), .d_line(d_line), .se0(se0), .bit_strobe(bit_strobe),
    .crc_din(crc_din), .crc_shift(crc_shift), .crc_clear(crc_clear),
    .rx_byte(rx_byte), .byte_valid(byte_valid), .rcving(rcving),
    .stuff_error(stuff_error), .align_error(align_error), .eop_seen(eop_seen)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected outputs for the current cycle.
  logic       e_din, e_shift, e_clear, e_bv, e_rcving, e_stuff, e_align, e_eop;
  logic [7:0] e_byte;
  // Effect the next strobe must have.
  logic       n_shift, n_din, n_clear, n_bv, n_eop, n_align, n_rcving, n_stuff;
  logic [7:0] n_byte;

  logic       line_lvl;
  logic       pay[$];
  logic [7:0] obs_bytes[$];
  logic [7:0] model_bytes[$];
  int         obs_shift = 0, obs_clear = 0, obs_eop = 0, obs_align = 0, obs_stuff = 0;
  logic [31:0] obs_bits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic zero_exp();
    {e_din, e_shift, e_clear, e_bv, e_rcving, e_stuff, e_align, e_eop} = '0;
    {n_shift, n_din, n_clear, n_bv, n_eop, n_align, n_rcving, n_stuff} = '0;
    e_byte = 8'h00;
    n_byte = 8'h00;
  endtask

  task automatic clear_pulses();
    {e_shift, e_clear, e_bv, e_align, e_eop} = '0;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      chk("crc_din", crc_din, e_din);
      chk("crc_shift", crc_shift, e_shift);
      chk("crc_clear", crc_clear, e_clear);
      chk("rx_byte", rx_byte, e_byte);
      chk("byte_valid", byte_valid, e_bv);
      chk("rcving", rcving, e_rcving);
      chk("stuff_error", stuff_error, e_stuff);
      chk("align_error", align_error, e_align);
      chk("eop_seen", eop_seen, e_eop);
      chk("clear_vs_shift", crc_clear & crc_shift, 0);
      if (crc_shift === 1'b1) begin
        obs_shift++;
        obs_bits = {obs_bits[30:0], crc_din};
      end
      if (crc_clear === 1'b1)   obs_clear++;
      if (eop_seen === 1'b1)    obs_eop++;
      if (align_error === 1'b1) obs_align++;
      if (stuff_error === 1'b1) obs_stuff++;
      if (byte_valid === 1'b1)  obs_bytes.push_back(rx_byte);
    end
  endtask

  // One strobe, then its expected effect for one cycle, then a random gap with line noise.
  task automatic do_strobe(input logic lvl, input logic se);
    d_line = lvl; se0 = se; bit_strobe = 1'b1;
    @(posedge clk); #1;
    bit_strobe = 1'b0;
    e_shift = n_shift; e_clear = n_clear; e_bv = n_bv; e_eop = n_eop; e_align = n_align;
    if (n_shift) e_din = n_din;
    if (n_bv) begin
      e_byte = n_byte;
      model_bytes.push_back(n_byte);
    end
    e_rcving = n_rcving; e_stuff = n_stuff;
    {n_shift, n_clear, n_bv, n_eop, n_align} = '0;
    repeat ($urandom_range(1, 3)) begin
      d_line = 1'($urandom_range(0, 1));
      se0    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      clear_pulses();
    end
  endtask

  task automatic send_bit(input logic b);
    if (!b) line_lvl = ~line_lvl;
    do_strobe(line_lvl, 1'b0);
  endtask

  task automatic send_se0();
    do_strobe(1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic push_bits(input logic [31:0] val, input int n);
    for (int i = 0; i < n; i++) pay.push_back(val[i]);
  endtask

  // Model: payload bits in pay; stuffing inserted here after six ones (SYNC's final 1 counts).
  task automatic send_packet(input bit violate, input int abort_at);
    int         ones, cnt;
    logic [7:0] acc;
    bit         in_err;
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    n_clear = 1'b1; n_rcving = 1'b1;
    send_bit(1'b1);
    ones = 1; cnt = 0; acc = 8'h00; in_err = 0;
    for (int i = 0; i < pay.size(); i++) begin
      if (i == abort_at) return;
      if (in_err) begin
        send_bit(pay[i]);
        continue;
      end
      if (ones == 6) begin
        if (violate && pay[i]) begin
          n_stuff = 1'b1; in_err = 1;
          send_bit(1'b1);
          continue;
        end
        send_bit(1'b0);
        ones = 0;
      end
      acc[cnt % 8] = pay[i];
      n_shift = 1'b1; n_din = pay[i];
      if (cnt % 8 == 7) begin
        n_bv = 1'b1; n_byte = acc;
      end
      ones = pay[i] ? ones + 1 : 0;
      cnt++;
      send_bit(pay[i]);
    end
    n_eop = 1'b1; n_align = !in_err && (cnt % 8 != 0);
    send_se0();
    if ($urandom_range(0, 1) == 1) send_se0();
    if ($urandom_range(0, 1) == 1) begin
      line_lvl = 1'b0;
      do_strobe(1'b0, 1'b0);
    end
    n_rcving = 1'b0; n_stuff = 1'b0; line_lvl = 1'b1;
    do_strobe(1'b1, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_din"}, crc_din, 0);
    chk({tag, "_shift"}, crc_shift, 0);
    chk({tag, "_clear"}, crc_clear, 0);
    chk({tag, "_byte"}, rx_byte, 0);
    chk({tag, "_bv"}, byte_valid, 0);
    chk({tag, "_rcving"}, rcving, 0);
    chk({tag, "_stuff"}, stuff_error, 0);
    chk({tag, "_align"}, align_error, 0);
    chk({tag, "_eop"}, eop_seen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_shift, b_clear, b_eop, b_align, b_bytes, b_stuff;
    nRst = 1'b0; d_line = 1'b1; se0 = 1'b0; bit_strobe = 1'b0; line_lvl = 1'b1;
    zero_exp();
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    nRst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // SYNC + 8'hA5
    b_shift = obs_shift; b_clear = obs_clear; b_bytes = obs_bytes.size();
    pay.delete(); push_bits(8'hA5, 8);
    send_packet(0, -1);
    chk("a5_clears", obs_clear - b_clear, 1);
    chk("a5_shifts", obs_shift - b_shift, 8);
    chk("a5_din_seq", obs_bits[7:0], 8'hA5);
    chk("a5_byte", obs_bytes[b_bytes], 8'hA5);
    chk("a5_model", model_bytes[model_bytes.size() - 1], 8'hA5);

    // Stuffing: 8'hFF, 8'h01
    b_shift = obs_shift; b_bytes = obs_bytes.size(); b_stuff = obs_stuff;
    pay.delete(); push_bits(8'hFF, 8); push_bits(8'h01, 8);
    send_packet(0, -1);
    chk("stuff_shifts", obs_shift - b_shift, 16);
    chk("stuff_byte0", obs_bytes[b_bytes], 8'hFF);
    chk("stuff_byte1", obs_bytes[b_bytes + 1], 8'h01);
    chk("stuff_no_err", obs_stuff - b_stuff, 0);

    // Stuff violation
    b_shift = obs_shift; b_eop = obs_eop; b_align = obs_align; b_stuff = obs_stuff;
    pay.delete(); push_bits(8'hFF, 8);
    send_packet(1, -1);
    chk("viol_shifts", obs_shift - b_shift, 5);
    chk("viol_eop", obs_eop - b_eop, 1);
    chk("viol_align", obs_align - b_align, 0);
    chk("viol_err_seen", (obs_stuff - b_stuff) > 0, 1);
    chk("viol_err_cleared", stuff_error, 0);

    // EOP alignment: 8'h3C plus three bits
    b_eop = obs_eop; b_align = obs_align; b_bytes = obs_bytes.size();
    pay.delete(); push_bits(8'h3C, 8); push_bits(3'b101, 3);
    send_packet(0, -1);
    chk("align_byte", obs_bytes[b_bytes], 8'h3C);
    chk("align_nbytes", obs_bytes.size() - b_bytes, 1);
    chk("align_eop", obs_eop - b_eop, 1);
    chk("align_err", obs_align - b_align, 1);
    chk("align_rcving_low", rcving, 0);

    // Bad SYNC (line 0,1,0,0), then a valid packet
    b_clear = obs_clear;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    chk("badsync_clear", obs_clear - b_clear, 0);
    chk("badsync_rcving", rcving, 0);
    pay.delete(); push_bits(8'h96, 8);
    send_packet(0, -1);
    chk("badsync_recover", obs_clear - b_clear, 1);

    // Reset in the middle of 8'h55
    pay.delete(); push_bits(8'h55, 8);
    send_packet(0, 4);
    chk("mid_rcving_high", rcving, 1);
    @(posedge clk); #2;
    zero_exp();
    nRst = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk); @(posedge clk); #1;
    nRst = 1'b1; line_lvl = 1'b1;
    b_eop = obs_eop; b_bytes = obs_bytes.size();
    pay.delete(); push_bits(8'h55, 8);
    send_packet(0, -1);
    chk("after_reset_byte", obs_bytes[b_bytes], 8'h55);
    chk("after_reset_eop", obs_eop - b_eop, 1);

    // Randomized traffic with idle noise, aborted SYNCs and occasional violations
    for (int p = 0; p < 50; p++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 1) begin
        repeat ($urandom_range(1, 4)) send_bit(1'b1);
        send_se0();
      end else if (kind == 2) begin
        repeat ($urandom_range(1, 6)) send_bit(1'b0);
        send_bit(1'b1);
      end else if (kind == 3) begin
        repeat ($urandom_range(1, 6)) send_bit(1'b0);
        send_se0();
      end
      pay.delete();
      repeat ($urandom_range(0, 40)) pay.push_back($urandom_range(0, 3) != 0);
      send_packet($urandom_range(0, 9) == 0, -1);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_rx_bit_decoder.md
Name: usb_rx_bit_decoder

Overview:
Receive front end for the USB full-speed data path. It NRZI-decodes the synchronized D+ line, detects SYNC and removes stuffed bits. It assembles LSB-first bytes and flags EOP. It also drives the serial CRC-16 checker that sits directly downstream: data bit, shift qualifier and per-packet clear.

Parameters:
STUFF_RUN, 6, consecutive decoded ones after which the next bit is a stuff bit
SYNC_PATTERN, 8'h80, decoded SYNC bits in arrival order (seven 0s, then a 1; bit0 arrives first)

Ports:
clk  input  1  system clock
nRst  input  1  asynchronous active-low reset
d_line  input  1  synchronized D+ level; idle J = 1
se0  input  1  synchronized single-ended-zero indication
bit_strobe  input  1  one-cycle pulse at each bit-centre sample point
crc_din  output  1  de-stuffed data bit to CRC checker
crc_shift  output  1  one-cycle pulse: crc_din is a new payload bit
crc_clear  output  1  one-cycle pulse: reset CRC checker at start of packet
rx_byte  output  8  last completed byte, LSB received first
byte_valid  output  1  one-cycle pulse: rx_byte updated
rcving  output  1  high from SYNC match until EOP handling completes
stuff_error  output  1  sticky: seven consecutive ones seen; cleared on return to IDLE
align_error  output  1  one-cycle pulse: EOP arrived with partial byte
eop_seen  output  1  one-cycle pulse on EOP detection

Behaviour:
- Reset (async, nRst=0): state IDLE, prev_line=1, all counters 0. All outputs 0, including rx_byte=8'h00.
- All outputs are registered and appear the cycle after the bit_strobe cycle that caused them.
- NRZI: evaluated only on bit_strobe with se0=0. Decoded bit = 1 if d_line==prev_line, else 0. prev_line <= d_line on every such strobe.
- se0=1 on a bit_strobe cycle: no bit is decoded and prev_line is not updated. se0 takes priority over the data bit.
- States:
  - IDLE: rcving=0. A decoded 0 moves to SYNC with sync_cnt=1. se0 and decoded 1 are ignored.
  - SYNC: compare each decoded bit against SYNC_PATTERN[sync_cnt]. On mismatch, go to IDLE. On a match of bit 7, go to DATA: crc_clear pulse, rcving=1, ones_cnt=1, bit_cnt=0. se0 in SYNC goes to IDLE with no flags.
  - DATA, decoded bit with ones_cnt==STUFF_RUN:
    - bit 0 = stuff bit: discard it (no crc_shift, no byte bit) and set ones_cnt=0.
    - bit 1: set stuff_error=1 and go to ERR.
  - DATA, otherwise:
    - crc_din=bit and crc_shift pulse.
    - Bit shifts into the byte shift register MSB-side; after 8 bits the first bit received is in bit 0.
    - ones_cnt increments on 1, clears on 0.
    - bit_cnt wraps 7->0. On wrap, rx_byte is loaded and byte_valid pulses.
  - DATA, se0 at bit_strobe: eop_seen pulse; align_error pulse if bit_cnt!=0. Go to EOP_WAIT.
  - EOP_WAIT: hold rcving=1 until a bit_strobe with se0=0 and d_line=1 (J). Then go to IDLE, rcving=0, prev_line=1.
  - ERR: rcving=1, stuff_error=1, no crc_shift or byte_valid. se0 at bit_strobe gives eop_seen and goes to EOP_WAIT. stuff_error clears on entry to IDLE.
- crc_din holds its last value when crc_shift=0.
- crc_clear never coincides with crc_shift.
- Back-to-back packets: IDLE is re-entered after EOP_WAIT; the next SYNC is accepted immediately.
- Reset mid-packet: immediate return to reset values; no eop_seen and no pulses.

Test Plan:
- SYNC + byte: line levels 0,1,0,1,0,1,0,0 then NRZI of 8'hA5 -> crc_clear once, rcving=1. Eight crc_shift pulses with crc_din 1,0,1,0,0,1,0,1. byte_valid with rx_byte=8'hA5.
- Stuffing: SYNC, then payload 8'hFF, 8'h01 with a stuffed 0 after the fifth payload 1 -> rx_byte 8'hFF then 8'h01. 16 crc_shift pulses total; stuff bit absent; stuff_error=0.
- Stuff violation: SYNC then seven decoded 1s with no stuff bit -> stuff_error=1 the cycle after the 7th-run bit. No further crc_shift. se0 gives eop_seen. J gives IDLE and stuff_error=0.
- EOP alignment: SYNC, 8'h3C, 3 extra bits, se0 -> byte_valid for 8'h3C, then eop_seen and align_error both pulse once. rcving falls after J.
- Bad SYNC: line 0,1,0,0 -> return to IDLE; no crc_clear, rcving stays 0. A following valid SYNC is accepted.
- Async reset mid-byte (bit 4 of 8'h55) -> all outputs 0 immediately. A subsequent full packet decodes 8'h55 correctly.
